// File: rtl/rr_stream_arbiter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_stream_arbiter_pkg: shared types and the wrap-around pick helper.
// Rev 1.0
// ------------------------------------------------------------------
package rr_stream_arbiter_pkg;

  localparam int PERF_CNT_W = 16;
  localparam int MAX_REQ    = 16;
  localparam int MAX_IDX_W  = 4;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of valid at or above ptr, wrapping modulo num_req.
  function automatic pick_t next_rr_index(input logic [MAX_REQ-1:0]   valid,
                                          input logic [MAX_IDX_W-1:0] ptr,
                                          input int                   num_req);
    pick_t res;
    int    j;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = (int'(ptr) + k) % num_req;
      if (k < num_req && !res.found && valid[j[MAX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = MAX_IDX_W'(j);
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_stream_arbiter_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick: combinational wrap-around priority picker.
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick
  import rr_stream_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  pick_t pick;

  always_comb begin
    pick  = next_rr_index(MAX_REQ'(valid), MAX_IDX_W'(ptr), NUM_REQ);
    idx   = IDX_W'(pick.idx);
    found = pick.found;
  end

endmodule
`default_nettype wire

// File: rtl/rr_stream_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_stream_arbiter: round-robin multi-beat stream arbiter, skid output.
// RR_STREAM_ARBITER_PERF_EN adds perf counters.  Rev 1.0
// ------------------------------------------------------------------
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 32,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ-1:0]       req_last_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [WIDTH-1:0]         output_data_out,
  output logic                     output_last_out,
  output logic [IDX_W-1:0]         output_index_out,
  output logic                     output_valid_out,
  input  logic                     output_ready_in
`ifdef RR_STREAM_ARBITER_PERF_EN
  ,
  output logic [NUM_REQ*PERF_CNT_W-1:0] perf_txn_count_out,
  output logic [31:0]                   perf_stall_count_out
`endif
);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               in_ready_ff;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  logic               ovf_valid;
  logic [WIDTH-1:0]   ovf_data;
  logic               ovf_last;
  logic [IDX_W-1:0]   ovf_index;

  logic               accept;
  logic               accept_last;
  logic               beat_last;
  logic [WIDTH-1:0]   beat_data;
  logic               pop;
  logic               load_direct;
  logic               load_ovf;
  logic               drain_ovf;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid (req_valid_in),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Both terms are flops, so ready never depends on any input combinationally.
  assign req_ready_out = grant_onehot & {NUM_REQ{in_ready_ff}};
  assign accept        = |(req_valid_in & req_ready_out);
  assign beat_last     = req_last_in[grant_idx];
  assign beat_data     = req_data_in[int'(grant_idx)*WIDTH +: WIDTH];
  assign accept_last   = accept & beat_last;
  assign pop           = output_valid_out & output_ready_in;

  assign load_direct   = accept & (~output_valid_out | output_ready_in);
  assign load_ovf      = accept & output_valid_out & ~output_ready_in;
  assign drain_ovf     = ~accept & pop & ovf_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB;
      rr_ptr       <= '0;
      grant_idx    <= '0;
      grant_onehot <= '0;
    end else begin
      case (state)
        ARB: begin
          if (pick_found) begin
            grant_idx    <= pick_idx;
            grant_onehot <= NUM_REQ'(1) << pick_idx;
            state        <= XFER;
          end
        end
        XFER: begin
          if (accept_last) begin
            grant_onehot <= '0;
            rr_ptr       <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
            state        <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Output/overflow control; a push only happens while overflow is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_valid_out <= 1'b0;
      output_last_out  <= 1'b0;
      output_index_out <= '0;
      ovf_valid        <= 1'b0;
      in_ready_ff      <= 1'b1;
    end else begin
      if (load_direct) begin
        output_valid_out <= 1'b1;
        output_last_out  <= beat_last;
        output_index_out <= grant_idx;
      end else if (drain_ovf) begin
        output_valid_out <= 1'b1;
        output_last_out  <= ovf_last;
        output_index_out <= ovf_index;
      end else if (pop) begin
        output_valid_out <= 1'b0;
      end

      if (load_ovf) begin
        ovf_valid   <= 1'b1;
        in_ready_ff <= 1'b0;
      end else if (drain_ovf) begin
        ovf_valid   <= 1'b0;
        in_ready_ff <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_direct) begin
      output_data_out <= beat_data;
    end else if (drain_ovf) begin
      output_data_out <= ovf_data;
    end
    if (load_ovf) begin
      ovf_data  <= beat_data;
      ovf_last  <= beat_last;
      ovf_index <= grant_idx;
    end
  end

`ifdef RR_STREAM_ARBITER_PERF_EN
  logic [31:0] stall_cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_txn_cnt
    logic [PERF_CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (accept_last && int'(grant_idx) == g && cnt != '1) begin
        cnt <= cnt + PERF_CNT_W'(1);
      end
    end
    assign perf_txn_count_out[g*PERF_CNT_W +: PERF_CNT_W] = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (output_valid_out && !output_ready_in) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
  assign perf_stall_count_out = stall_cnt;
`endif

`ifndef SYNTHESIS
  logic [NUM_REQ-1:0] waiting;
  logic               mid_txn;
  logic [IDX_W-1:0]   txn_index;

  always_ff @(posedge clk) begin
    if (rst) begin
      waiting   <= '0;
      mid_txn   <= 1'b0;
      txn_index <= '0;
    end else begin
      waiting <= req_valid_in & ~req_ready_out;
      if (pop) begin
        mid_txn   <= ~output_last_out;
        txn_index <= output_index_out;
      end
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready_out));
  a_valid_held: assert property (@(posedge clk) disable iff (rst)
    (waiting & ~req_valid_in) == '0);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(accept && ovf_valid));
  a_index_stable: assert property (@(posedge clk) disable iff (rst)
    (output_valid_out && mid_txn) |-> (output_index_out == txn_index));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_rr_stream_arbiter: scoreboard bench with a transaction-level RR model.
// Rev 1.0
// ------------------------------------------------------------------
module tb_rr_stream_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IW   = $clog2(NREQ);

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          last;
    logic [IW-1:0] idx;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ*W-1:0] req_data_in;
  logic [NREQ-1:0]   req_valid_in;
  logic [NREQ-1:0]   req_last_in;
  logic [NREQ-1:0]   req_ready_out;
  logic [W-1:0]      output_data_out;
  logic              output_last_out;
  logic [IW-1:0]     output_index_out;
  logic              output_valid_out;
  logic              output_ready_in;
`ifdef RR_STREAM_ARBITER_PERF_EN
  logic [NREQ*16-1:0] perf_txn_count_out;
  logic [31:0]        perf_stall_count_out;
`endif

  always #5 clk = ~clk;

  rr_stream_arbiter #(
    .NUM_REQ (NREQ),
    .WIDTH   (W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_data_in      (req_data_in),
    .req_valid_in     (req_valid_in),
    .req_last_in      (req_last_in),
    .req_ready_out    (req_ready_out),
    .output_data_out  (output_data_out),
    .output_last_out  (output_last_out),
    .output_index_out (output_index_out),
    .output_valid_out (output_valid_out),
    .output_ready_in  (output_ready_in)
`ifdef RR_STREAM_ARBITER_PERF_EN
    ,
    .perf_txn_count_out   (perf_txn_count_out),
    .perf_stall_count_out (perf_stall_count_out)
`endif
  );

  beat_t src_q[NREQ][$];
  beat_t stage_q[NREQ][$];
  int    stage_cnt[NREQ];
  exp_t  exp_q[$];
  int    mdl_ptr;
  int    mdl_txn[NREQ];
  int    mdl_stall;
  int    vectors;
  int    miscompares;
  logic  ds_random;
  logic  ds_fixed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic add_txn(input int r, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = $urandom;
      bt.last = (b == len - 1);
      stage_q[r].push_back(bt);
    end
    stage_cnt[r]++;
  endtask

  // Transaction-level round robin: whole transactions, winner = first
  // requester at or after the pointer with work left, pointer = winner+1.
  task automatic commit();
    int    r;
    beat_t bt;
    exp_t  e;
    while (1) begin
      r = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (r < 0 && stage_cnt[(mdl_ptr + k) % NREQ] > 0) r = (mdl_ptr + k) % NREQ;
      end
      if (r < 0) break;
      do begin
        bt = stage_q[r].pop_front();
        src_q[r].push_back(bt);
        e.data = bt.data;
        e.last = bt.last;
        e.idx  = IW'(r);
        exp_q.push_back(e);
      end while (!bt.last);
      stage_cnt[r]--;
      mdl_txn[r]++;
      mdl_ptr = (r + 1) % NREQ;
    end
  endtask

  task automatic drain(input string name, input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      step();
      cycles++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Requester drivers: hold each beat until it is accepted.
  initial begin
    logic [NREQ-1:0] acc;
    req_valid_in = '0;
    req_last_in  = '0;
    req_data_in  = '0;
    forever begin
      @(negedge clk);
      acc = rst ? '0 : (req_valid_in & req_ready_out);
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (acc[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
        if (src_q[r].size() > 0) begin
          req_valid_in[r]        = 1'b1;
          req_data_in[r*W +: W]  = src_q[r][0].data;
          req_last_in[r]         = src_q[r][0].last;
        end else begin
          req_valid_in[r] = 1'b0;
          req_last_in[r]  = 1'b0;
        end
      end
    end
  end

  initial begin
    output_ready_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      output_ready_in = ds_random ? ($urandom_range(3) != 0) : ds_fixed;
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && output_valid_out && !output_ready_in) mdl_stall++;
      if (!rst && output_valid_out && output_ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({output_index_out, output_last_out, output_data_out}),
                64'({e.idx, e.last, e.data}));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cyc;
    int    mask;
    beat_t first;
    vectors     = 0;
    miscompares = 0;
    mdl_ptr     = 0;
    mdl_stall   = 0;
    ds_random   = 1'b0;
    ds_fixed    = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      stage_cnt[r] = 0;
      mdl_txn[r]   = 0;
    end
    rst = 1'b1;
    repeat (3) step();
    check("rst_ready", 64'(req_ready_out), 64'(0));
    check("rst_valid", 64'(output_valid_out), 64'(0));
    check("rst_last", 64'(output_last_out), 64'(0));
    check("rst_index", 64'(output_index_out), 64'(0));
    rst       = 1'b0;
    mdl_stall = 0;
    step();

    // Single 3-beat transaction from requester 0.
    add_txn(0, 3);
    commit();
    step();
    check("bubble_ready", 64'(req_ready_out), 64'(4'b0000));
    step();
    check("xfer_ready_1", 64'(req_ready_out), 64'(4'b0001));
    step();
    check("xfer_ready_2", 64'(req_ready_out), 64'(4'b0001));
    check("first_out_valid", 64'(output_valid_out), 64'(1));
    step();
    check("xfer_ready_3", 64'(req_ready_out), 64'(4'b0001));
    step();
    check("release_ready", 64'(req_ready_out), 64'(4'b0000));
    drain("single", 50, cyc);

    // All four requesters, single-beat transactions, three rounds.
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < NREQ; r++) add_txn(r, 1);
    commit();
    drain("all_rr", 100, cyc);
    check("rr_throughput", 64'(cyc <= 26), 64'(1));

    // Requester 1 and 3 arrive while requester 2 is mid-transaction.
    add_txn(2, 4);
    commit();
    step();
    step();
    add_txn(1, 1);
    add_txn(3, 1);
    commit();
    step();
    check("hold_grant_a", 64'(req_ready_out), 64'(4'b0100));
    step();
    check("hold_grant_b", 64'(req_ready_out), 64'(4'b0100));
    drain("mid_txn", 100, cyc);

    // Downstream stall for 5 cycles during a 4-beat burst.
    ds_fixed = 1'b0;
    add_txn(0, 4);
    first = stage_q[0][0];
    commit();
    repeat (4) step();
    check("stall_ready", 64'(req_ready_out), 64'(0));
    check("stall_hold_data", 64'(output_data_out), 64'(first.data));
    step();
    check("stall_ready_b", 64'(req_ready_out), 64'(0));
    check("stall_hold_valid", 64'(output_valid_out), 64'(1));
    ds_fixed = 1'b1;
    drain("stall", 100, cyc);

    // Randomised phases with random downstream back-pressure.
    ds_random = 1'b1;
    for (int p = 0; p < 15; p++) begin
      mask = $urandom_range(15, 1);
      for (int r = 0; r < NREQ; r++)
        if (mask[r]) begin
          int ntx;
          ntx = $urandom_range(3, 1);
          for (int t = 0; t < ntx; t++) add_txn(r, $urandom_range(4, 1));
        end
      commit();
      drain("random", 600, cyc);
    end
    ds_random = 1'b0;
    ds_fixed  = 1'b1;
    step();

    // Reset in the middle of a burst from requester 2.
    add_txn(2, 6);
    commit();
    repeat (4) step();
    rst = 1'b1;
    exp_q.delete();
    for (int r = 0; r < NREQ; r++) begin
      src_q[r].delete();
      mdl_txn[r] = 0;
    end
    mdl_ptr   = 0;
    mdl_stall = 0;
    add_txn(3, 2);
    add_txn(1, 1);
    commit();
    step();
    rst = 1'b0;
    check("midrst_ready", 64'(req_ready_out), 64'(0));
    check("midrst_valid", 64'(output_valid_out), 64'(0));
    check("midrst_last", 64'(output_last_out), 64'(0));
    check("midrst_index", 64'(output_index_out), 64'(0));
    step();
    check("post_rst_grant", 64'(req_ready_out), 64'(4'b0010));
    drain("post_rst", 100, cyc);

    // Requester 1 runs three transactions under back-pressure.
    ds_random = 1'b1;
    for (int t = 0; t < 3; t++) add_txn(1, 2);
    commit();
    drain("perf", 200, cyc);
    ds_random = 1'b0;
    ds_fixed  = 1'b1;
    repeat (2) step();
`ifdef RR_STREAM_ARBITER_PERF_EN
    for (int r = 0; r < NREQ; r++)
      check("perf_txn", 64'(perf_txn_count_out[r*16 +: 16]), 64'(mdl_txn[r]));
    check("perf_stall", 64'(perf_stall_count_out), 64'(mdl_stall));
`endif
    check("final_idle_valid", 64'(output_valid_out), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
